// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and fetch state encoding for the core
package riscv_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h00000000;
  localparam logic FETCH = 1'b0;
  localparam logic HOLD = 1'b1;
  typedef enum logic {ST_FETCH = FETCH, ST_HOLD = HOLD} fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: control, instruction-memory and IF/ID signals of the fetch stage
interface instr_fetch_if #(parameter int width = 32);
  logic stall;
  logic flush;
  logic branch_taken;
  logic [width-1:0] branch_target;
  logic imem_req;
  logic [width-1:0] imem_addr;
  logic imem_ready;
  logic [31:0] imem_rdata;
  logic if_valid;
  logic [31:0] if_instr;
  logic [width-1:0] if_pc;
  logic [width-1:0] if_pc_plus4;
  modport master (
    input stall, flush, branch_taken, branch_target, imem_ready, imem_rdata,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4
  );
  modport slave (
    output stall, flush, branch_taken, branch_target, imem_ready, imem_rdata,
    input imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4
  );
endinterface

// File: rtl/pc_register.sv
// pc_register: loadable program counter with synchronous reset
module pc_register #(
  parameter int width = 32,
  parameter logic [width-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= RESET_PC;
    else if (en) q <= d;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, imem handshake, skid buffer and IF/ID register with stall/flush/redirect
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int width = 32,
  parameter logic [width-1:0] RESET_PC = width'(DEFAULT_RESET_PC)
) (
  input logic clk,
  input logic rst,
  instr_fetch_if.master bus
);
  fetch_state_t state, state_n;
  logic [width-1:0] pc, pc_n, skid_pc;
  logic [31:0] skid_instr;
  logic hs, kill, pc_en, load_mem, park, load_skid, bubble;
  assign bus.imem_req = !rst && state == ST_FETCH;
  assign bus.imem_addr = pc;
  pc_register #(.width(width), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .en(pc_en), .d(pc_n), .q(pc)
  );
  always_comb begin
    hs = bus.imem_req && bus.imem_ready;
    kill = bus.branch_taken || bus.flush;
    load_mem = state == ST_FETCH && hs && !bus.stall && !kill;
    park = state == ST_FETCH && hs && bus.stall && !kill;
    load_skid = state == ST_HOLD && !bus.stall && !kill;
    bubble = state == ST_FETCH && !hs && !bus.stall && !kill;
    pc_en = bus.branch_taken || hs;
    pc_n = bus.branch_taken ? {bus.branch_target[width-1:2], 2'b00} : pc + width'(4);
    state_n = (kill || load_skid) ? ST_FETCH : park ? ST_HOLD : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      skid_instr <= '0;
      skid_pc <= '0;
      bus.if_valid <= 1'b0;
      bus.if_instr <= NOP_INSTR;
      bus.if_pc <= RESET_PC;
      bus.if_pc_plus4 <= RESET_PC + width'(4);
    end else begin
      state <= state_n;
      if (park) begin
        skid_instr <= bus.imem_rdata;
        skid_pc <= pc;
      end
      if (kill) begin
        bus.if_valid <= 1'b0;
        bus.if_instr <= NOP_INSTR;
      end else if (load_mem) begin
        bus.if_valid <= 1'b1;
        bus.if_instr <= bus.imem_rdata;
        bus.if_pc <= pc;
        bus.if_pc_plus4 <= pc + width'(4);
      end else if (load_skid) begin
        bus.if_valid <= 1'b1;
        bus.if_instr <= skid_instr;
        bus.if_pc <= skid_pc;
        bus.if_pc_plus4 <= skid_pc + width'(4);
      end else if (bubble) begin
        bus.if_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random checks of two fetch stages against a skid-occupancy model
module tb_instr_fetch;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] RP0 = 32'h00000000;
  localparam logic [31:0] RP1 = 32'hFFFFFFF8;
  typedef struct packed {
    logic rst, stall, flush, br, ready;
    logic [31:0] tgt;
  } in_t;
  typedef struct packed {
    logic [31:0] pc, ifpc, instr, skid_instr, skid_pc;
    logic valid, has_skid;
  } mdl_t;
  logic clk = 1'b0;
  int total = 0;
  int bad = 0;
  in_t in0, in1;
  mdl_t m0, m1;
  instr_fetch_if #(.width(32)) b0 ();
  instr_fetch_if #(.width(32)) b1 ();
  instr_fetch #(.width(32), .RESET_PC(RP0)) dut0 (.clk(clk), .rst(in0.rst), .bus(b0.master));
  instr_fetch #(.width(32), .RESET_PC(RP1)) dut1 (.clk(clk), .rst(in1.rst), .bus(b1.master));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h0 ? 32'h00100093 : a == 32'h4 ? 32'h00200113 : a == 32'h8 ? 32'h00300193 :
           (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  assign b0.stall = in0.stall;
  assign b0.flush = in0.flush;
  assign b0.branch_taken = in0.br;
  assign b0.branch_target = in0.tgt;
  assign b0.imem_ready = in0.ready;
  assign b0.imem_rdata = mem_word(b0.imem_addr);
  assign b1.stall = in1.stall;
  assign b1.flush = in1.flush;
  assign b1.branch_taken = in1.br;
  assign b1.branch_target = in1.tgt;
  assign b1.imem_ready = in1.ready;
  assign b1.imem_rdata = mem_word(b1.imem_addr);
  function automatic mdl_t step(input mdl_t m, input in_t i, input logic [31:0] rp);
    mdl_t n = m;
    logic hs = !m.has_skid && i.ready;
    logic [31:0] w = mem_word(m.pc);
    if (i.rst) begin
      n.pc = rp;
      n.ifpc = rp;
      n.valid = 1'b0;
      n.instr = NOP;
      n.has_skid = 1'b0;
      return n;
    end
    if (i.br) begin
      n.pc = i.tgt & ~32'h3;
      n.has_skid = 1'b0;
      n.valid = 1'b0;
      n.instr = NOP;
      return n;
    end
    if (hs) n.pc = m.pc + 32'd4;
    if (i.flush) begin
      n.valid = 1'b0;
      n.instr = NOP;
      n.has_skid = 1'b0;
    end else if (m.has_skid) begin
      if (!i.stall) begin
        n.valid = 1'b1;
        n.instr = m.skid_instr;
        n.ifpc = m.skid_pc;
        n.has_skid = 1'b0;
      end
    end else if (hs) begin
      if (i.stall) begin
        n.has_skid = 1'b1;
        n.skid_instr = w;
        n.skid_pc = m.pc;
      end else begin
        n.valid = 1'b1;
        n.instr = w;
        n.ifpc = m.pc;
      end
    end else if (!i.stall) begin
      n.valid = 1'b0;
    end
    return n;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_dut(input string n, input mdl_t m, input logic rst, input logic req,
                           input logic [31:0] addr, input logic valid, input logic [31:0] instr,
                           input logic [31:0] pc, input logic [31:0] plus4);
    check({n, ".req"}, 32'(req), 32'(!rst && !m.has_skid));
    check({n, ".addr"}, addr, m.pc);
    check({n, ".valid"}, 32'(valid), 32'(m.valid));
    check({n, ".instr"}, instr, m.instr);
    check({n, ".pc"}, pc, m.ifpc);
    check({n, ".pc4"}, plus4, m.ifpc + 32'd4);
  endtask
  task automatic tick();
    m0 = step(m0, in0, RP0);
    m1 = step(m1, in1, RP1);
    @(posedge clk);
    #1;
    check_dut("d0", m0, in0.rst, b0.imem_req, b0.imem_addr, b0.if_valid, b0.if_instr, b0.if_pc, b0.if_pc_plus4);
    check_dut("d1", m1, in1.rst, b1.imem_req, b1.imem_addr, b1.if_valid, b1.if_instr, b1.if_pc, b1.if_pc_plus4);
  endtask
  initial begin
    m0 = '0;
    m1 = '0;
    in0 = '0;
    in1 = '0;
    in0.rst = 1'b1;
    in1.rst = 1'b1;
    in0.ready = 1'b1;
    in1.ready = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(b0.if_valid), 32'd0);
    check("rst_instr", b0.if_instr, NOP);
    check("rst_req", 32'(b0.imem_req), 32'd0);
    check("rst_pc4_wrap", b1.if_pc_plus4, 32'hFFFFFFFC);
    in0.rst = 1'b0;
    in1.rst = 1'b0;
    tick();
    check("seq_pc0", b0.if_pc, 32'h0);
    check("seq_instr0", b0.if_instr, 32'h00100093);
    check("wrap_pc0", b1.if_pc, 32'hFFFFFFF8);
    tick();
    check("seq_pc1", b0.if_pc, 32'h4);
    check("seq_pc4_1", b0.if_pc_plus4, 32'h8);
    check("wrap_pc1", b1.if_pc, 32'hFFFFFFFC);
    check("wrap_pc4", b1.if_pc_plus4, 32'h0);
    check("wrap_addr", b1.imem_addr, 32'h0);
    in0.ready = 1'b0;
    in1.stall = 1'b1;
    tick();
    check("wait_addr", b0.imem_addr, 32'h8);
    check("wait_bubble", 32'(b0.if_valid), 32'd0);
    check("hold_req", 32'(b1.imem_req), 32'd0);
    in1.rst = 1'b1;
    tick();
    check("hold_rst_valid", 32'(b1.if_valid), 32'd0);
    check("hold_rst_addr", b1.imem_addr, RP1);
    in1.rst = 1'b0;
    in1.stall = 1'b0;
    tick();
    check("wait_addr3", b0.imem_addr, 32'h8);
    in0.ready = 1'b1;
    tick();
    check("wait_pc", b0.if_pc, 32'h8);
    check("wait_instr", b0.if_instr, 32'h00300193);
    tick();
    in0.stall = 1'b1;
    tick();
    check("stall_pc", b0.if_pc, 32'hC);
    check("stall_req", 32'(b0.imem_req), 32'd0);
    tick();
    check("stall_pc2", b0.if_pc, 32'hC);
    in0.stall = 1'b0;
    tick();
    check("unstall_pc", b0.if_pc, 32'h10);
    check("unstall_instr", b0.if_instr, mem_word(32'h10));
    tick();
    check("after_skid_pc", b0.if_pc, 32'h14);
    tick();
    tick();
    in0.br = 1'b1;
    in0.tgt = 32'h103;
    tick();
    check("br_addr", b0.imem_addr, 32'h100);
    check("br_valid", 32'(b0.if_valid), 32'd0);
    check("br_instr", b0.if_instr, NOP);
    in0.br = 1'b0;
    tick();
    check("br_target_pc", b0.if_pc, 32'h100);
    for (int k = 0; k < 2000; k++) begin
      in0.rst = $urandom_range(0, 99) == 0;
      in0.stall = $urandom_range(0, 3) == 0;
      in0.flush = $urandom_range(0, 15) == 0;
      in0.br = $urandom_range(0, 15) == 0;
      in0.tgt = 32'($urandom_range(0, 32'h400));
      in0.ready = $urandom_range(0, 3) != 0;
      in1.rst = $urandom_range(0, 99) == 0;
      in1.stall = $urandom_range(0, 2) == 0;
      in1.flush = $urandom_range(0, 15) == 0;
      in1.br = $urandom_range(0, 15) == 0;
      in1.tgt = $urandom;
      in1.ready = $urandom_range(0, 2) != 0;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
